rom_fetch_arbiter: RTL
======================

# rom_fetch_arbiter

Shares one SDRAM read channel among three ROM requesters: the 68K program fetch (`m68k_rom_cs`/`m68k_rom_2_cs` regions), the Z80 sound fetch (fixed and banked windows) and a graphics fetch port. It owns the Z80 sound-bank register written through `z80_bank_set_cs`, translates each requester's address into a flat SDRAM word address and returns data with a one-cycle acknowledge. It sits between the chip-select decode and the SDRAM controller.

## Interface
- Z80_BASE, 24'h080000, SDRAM byte offset of the Z80 ROM image
- STARVE_LIMIT, 8, consecutive gfx losses before gfx is forced to win once
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m68k_rom_cs, m68k_rom_2_cs  in  1  68K ROM region selects; the 68K request is their OR
- m68k_a  in  24  68K byte address
- m68k_dout  out  16  fetched word
- m68k_ack  out  1  one-cycle data-valid pulse
- z80_rom_cs, z80_banked_cs  in  1  Z80 fixed/banked selects; the Z80 request is their OR
- z80_addr  in  16  Z80 address
- z80_bank_set_cs  in  1  bank-register write select (level)
- z80_din  in  8  Z80 data bus, bits [4:0] = bank
- z80_dout  out  8  fetched byte
- z80_ack  out  1  one-cycle data-valid pulse
- gfx_req  in  1  graphics request (level)
- gfx_addr  in  22  graphics word address [22:1]
- gfx_dout  out  16  fetched word
- gfx_ack  out  1  one-cycle data-valid pulse
- sdram_req  out  1  one-cycle read strobe
- sdram_addr  out  22  word address [22:1]
- sdram_data  in  16  read data
- sdram_valid  in  1  one-cycle read-data strobe

## Operation
- Each requester has a served flag. A request is pending when its request is high and served=0. Served is set on ack and cleared whenever the request is low.
- Address translation is captured at grant:
  - 68K: 0x000000–0x03FFFF maps to byte offset = m68k_a[17:0]. 0x800000–0x83FFFF maps to 0x40000 + m68k_a[17:0].
  - Z80 fixed window: Z80_BASE + z80_addr[14:0].
  - Z80 banked window: Z80_BASE + {bank[4:0], z80_addr[13:0]}.
  - gfx: gfx_addr as given.
- Z80 byte select: z80_addr[0]=0 returns sdram_data[15:8]; z80_addr[0]=1 returns [7:0].
- Bank register: 5 bits, loaded from z80_din[4:0] on the rising edge of z80_bank_set_cs.
- Arbitration happens in IDLE only:
  - If both 68K and Z80 are pending, grant the one not granted last (last_grant toggles).
  - If only one of them is pending, grant it.
  - gfx wins only if neither is pending, or if starve_cnt == STARVE_LIMIT; forced gfx wins over both.
  - starve_cnt increments on each 68K/Z80 grant while gfx is pending. It clears on a gfx grant or when gfx_req is low.
- States:
  - IDLE: on grant, go to ISSUE.
  - ISSUE: sdram_req=1 with sdram_addr; go to WAIT.
  - WAIT: on sdram_valid, register data; go to RESP.
  - RESP: pulse the granted ack, with dout valid; go to IDLE.
- A requester that drops its request while granted still completes its SDRAM cycle. Its data is discarded and no ack is issued.
- sdram_valid outside WAIT is ignored.

## Timing
- Reset values:
  - State IDLE.
  - All acks and sdram_req 0; all dout 0; sdram_addr 0.
  - bank 0, starve_cnt 0, served flags 0.
  - last_grant = Z80, so the 68K wins the first tie.
- Pending in IDLE at cycle N gives sdram_req at N+1.
- sdram_valid at cycle V gives ack and dout at V+1. dout holds until the next ack for that port.
- Back-to-back: the next sdram_req occurs 2 cycles after an ack at the earliest (RESP → IDLE → ISSUE).
- A bank write in the same cycle as a Z80 grant: the grant uses the old bank. A bank write during an in-flight transaction does not alter it.
- Reset mid-transaction: immediate return to IDLE, no ack. A late sdram_valid is ignored.

## Structure
- Package alpha68k_mem_pkg: state enum, requester ID encoding (M68K=0, Z80=1, GFX=2), ROM region bounds, rom_2 offset 0x40000.
- Sub-module rom_req_tracker, instantiated 3×: request level in, served flag, pending out, ack in.

## Test plan
- 68K reads 0x000100 (sdram latency 4): sdram_addr=0x000080, and m68k_ack arrives exactly 1 cycle after sdram_valid with dout = sdram_data.
- 68K reads 0x800002: sdram_addr word 0x020001.
- Bank write 0x13, then Z80 reads 0xC001: byte offset 0x080000+0x4C001, sdram_addr=0x066000, z80_dout = sdram_data[7:0].
- 68K and Z80 pending continuously after reset: grants alternate M68K, Z80, M68K, …; no requester is served twice without dropping its request.
- gfx held with 68K/Z80 saturating and STARVE_LIMIT=8: gfx is granted on the 9th arbitration, and starve_cnt returns to 0.
- Assert reset during WAIT, then inject sdram_valid: no ack, state IDLE, and the next request proceeds normally.

Source files
------------

// File: rtl/rom_fetch_arbiter_pkg.sv
// Shared types and constants for the ROM fetch arbiter.
// Requester IDs, FSM states and address-map constants.
package alpha68k_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        REQ_M68K = 2'd0,
        REQ_Z80  = 2'd1,
        REQ_GFX  = 2'd2
    } req_id_e;

    localparam logic [23:0] Z80_BASE_DEF     = 24'h080000;
    localparam int          STARVE_LIMIT_DEF = 8;
    localparam int          STARVE_W         = 8;

    localparam logic [23:0] ROM1_BASE   = 24'h000000;
    localparam logic [23:0] ROM2_BASE   = 24'h800000;
    localparam logic [23:0] ROM2_OFFSET = 24'h040000;

    function automatic logic [7:0] pick_byte(
        input logic [15:0] w,
        input logic        odd
    );
        return odd ? w[7:0] : w[15:8];
    endfunction

endpackage

// File: rtl/rom_fetch_arbiter_if.sv
// Requester and SDRAM-side signal bundle of the ROM fetch arbiter.
// The arbiter takes the slave view; the surrounding logic the master view.
interface rom_fetch_arbiter_if;
    logic        m68k_rom_cs;
    logic        m68k_rom_2_cs;
    logic [23:0] m68k_a;
    logic [15:0] m68k_dout;
    logic        m68k_ack;
    logic        z80_rom_cs;
    logic        z80_banked_cs;
    logic [15:0] z80_addr;
    logic        z80_bank_set_cs;
    logic [7:0]  z80_din;
    logic [7:0]  z80_dout;
    logic        z80_ack;
    logic        gfx_req;
    logic [21:0] gfx_addr;
    logic [15:0] gfx_dout;
    logic        gfx_ack;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic [15:0] sdram_data;
    logic        sdram_valid;

    modport slave (
        input  m68k_rom_cs, m68k_rom_2_cs, m68k_a,
        input  z80_rom_cs, z80_banked_cs, z80_addr,
        input  z80_bank_set_cs, z80_din,
        input  gfx_req, gfx_addr,
        input  sdram_data, sdram_valid,
        output m68k_dout, m68k_ack,
        output z80_dout, z80_ack,
        output gfx_dout, gfx_ack,
        output sdram_req, sdram_addr
    );

    modport master (
        output m68k_rom_cs, m68k_rom_2_cs, m68k_a,
        output z80_rom_cs, z80_banked_cs, z80_addr,
        output z80_bank_set_cs, z80_din,
        output gfx_req, gfx_addr,
        output sdram_data, sdram_valid,
        input  m68k_dout, m68k_ack,
        input  z80_dout, z80_ack,
        input  gfx_dout, gfx_ack,
        input  sdram_req, sdram_addr
    );
endinterface

// File: rtl/rom_req_tracker.sv
// Per-requester served flag: one fetch per request level,
// re-armed only once the requester drops its request.
module rom_req_tracker (
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    input  logic ack_i,
    output logic pending_o
);
    logic served_q;
    logic served_d;

    always_comb begin
        served_d = served_q;
        if (!req_i)
            served_d = 1'b0;
        else if (ack_i)
            served_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            served_q <= 1'b0;
        else
            served_q <= served_d;
    end

    assign pending_o = req_i & ~served_q;
endmodule

// File: rtl/rom_fetch_arbiter.sv
// Shares one SDRAM read channel among 68K, Z80 and graphics ROM fetches.
// Owns the Z80 sound bank register and the flat SDRAM address map.
module rom_fetch_arbiter
    import alpha68k_mem_pkg::*;
#(
    parameter logic [23:0] Z80_BASE     = Z80_BASE_DEF,
    parameter int          STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    rom_fetch_arbiter_if.slave bus
);
    state_e  state_q, state_d;
    req_id_e cur_q, last_q, gnt_id;

    logic m68k_req, z80_req, cur_req;
    logic m68k_pend, z80_pend, gfx_pend;
    logic gnt_valid, force_gfx, idle_gnt;

    logic [STARVE_W-1:0] starve_q;
    logic [4:0]  bank_q;
    logic        bank_cs_q, byte_q, abort_q;
    logic [23:0] m68k_byte, z80_byte;
    logic [21:0] gnt_addr;
    logic        unused_bits;

    logic        sdram_req_q;
    logic [21:0] sdram_addr_q;
    logic        m68k_ack_q, z80_ack_q, gfx_ack_q;
    logic [15:0] m68k_dout_q, gfx_dout_q;
    logic [7:0]  z80_dout_q;

    assign m68k_req = bus.m68k_rom_cs | bus.m68k_rom_2_cs;
    assign z80_req  = bus.z80_rom_cs | bus.z80_banked_cs;

    rom_req_tracker u_trk_m68k (
        .clk(clk), .reset(reset), .req_i(m68k_req),
        .ack_i(m68k_ack_q), .pending_o(m68k_pend)
    );
    rom_req_tracker u_trk_z80 (
        .clk(clk), .reset(reset), .req_i(z80_req),
        .ack_i(z80_ack_q), .pending_o(z80_pend)
    );
    rom_req_tracker u_trk_gfx (
        .clk(clk), .reset(reset), .req_i(bus.gfx_req),
        .ack_i(gfx_ack_q), .pending_o(gfx_pend)
    );

    // A starved gfx port beats both CPUs; CPU ties alternate.
    always_comb begin
        gnt_valid = m68k_pend | z80_pend | gfx_pend;
        force_gfx = gfx_pend && (starve_q == STARVE_W'(STARVE_LIMIT));
        gnt_id    = REQ_GFX;
        if (force_gfx)
            gnt_id = REQ_GFX;
        else if (m68k_pend && z80_pend)
            gnt_id = (last_q == REQ_Z80) ? REQ_M68K : REQ_Z80;
        else if (m68k_pend)
            gnt_id = REQ_M68K;
        else if (z80_pend)
            gnt_id = REQ_Z80;
    end

    assign idle_gnt = (state_q == S_IDLE) && gnt_valid;

    always_comb begin
        m68k_byte = {6'd0, bus.m68k_a[17:0]}
                  + (bus.m68k_rom_2_cs ? ROM2_OFFSET : ROM1_BASE);
        z80_byte  = Z80_BASE + (bus.z80_banked_cs
                  ? {5'd0, bank_q, bus.z80_addr[13:0]}
                  : {9'd0, bus.z80_addr[14:0]});
        gnt_addr  = '0;
        unique case (gnt_id)
            REQ_M68K: gnt_addr = m68k_byte[22:1];
            REQ_Z80:  gnt_addr = z80_byte[22:1];
            REQ_GFX:  gnt_addr = bus.gfx_addr;
            default:  gnt_addr = '0;
        endcase
    end

    always_comb begin
        cur_req = 1'b0;
        unique case (cur_q)
            REQ_M68K: cur_req = m68k_req;
            REQ_Z80:  cur_req = z80_req;
            REQ_GFX:  cur_req = bus.gfx_req;
            default:  cur_req = 1'b0;
        endcase
    end

    assign unused_bits = ^{bus.m68k_a[23:18], bus.z80_addr[15],
                           bus.z80_din[7:5], m68k_byte[23], m68k_byte[0],
                           z80_byte[23], z80_byte[0], ROM2_BASE};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (gnt_valid) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (bus.sdram_valid) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_q        <= REQ_M68K;
            last_q       <= REQ_Z80;
            starve_q     <= '0;
            bank_q       <= '0;
            bank_cs_q    <= 1'b0;
            byte_q       <= 1'b0;
            abort_q      <= 1'b0;
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= '0;
            m68k_ack_q   <= 1'b0;
            z80_ack_q    <= 1'b0;
            gfx_ack_q    <= 1'b0;
            m68k_dout_q  <= '0;
            z80_dout_q   <= '0;
            gfx_dout_q   <= '0;
        end else begin
            sdram_req_q <= 1'b0;
            m68k_ack_q  <= 1'b0;
            z80_ack_q   <= 1'b0;
            gfx_ack_q   <= 1'b0;
            bank_cs_q   <= bus.z80_bank_set_cs;
            if (bus.z80_bank_set_cs && !bank_cs_q)
                bank_q <= bus.z80_din[4:0];

            if (!bus.gfx_req)
                starve_q <= '0;
            else if (idle_gnt) begin
                if (gnt_id == REQ_GFX)
                    starve_q <= '0;
                else if (gfx_pend)
                    starve_q <= starve_q + 1'b1;
            end

            if (idle_gnt) begin
                cur_q        <= gnt_id;
                sdram_req_q  <= 1'b1;
                sdram_addr_q <= gnt_addr;
                byte_q       <= bus.z80_addr[0];
                abort_q      <= 1'b0;
                if (gnt_id != REQ_GFX)
                    last_q <= gnt_id;
            end else if (state_q != S_IDLE && !cur_req) begin
                abort_q <= 1'b1;
            end

            // A dropped request still drains its SDRAM cycle, silently.
            if (state_q == S_WAIT && bus.sdram_valid && !abort_q && cur_req) begin
                unique case (cur_q)
                    REQ_M68K: begin
                        m68k_dout_q <= bus.sdram_data;
                        m68k_ack_q  <= 1'b1;
                    end
                    REQ_Z80: begin
                        z80_dout_q <= pick_byte(bus.sdram_data, byte_q);
                        z80_ack_q  <= 1'b1;
                    end
                    REQ_GFX: begin
                        gfx_dout_q <= bus.sdram_data;
                        gfx_ack_q  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.sdram_req  = sdram_req_q;
    assign bus.sdram_addr = sdram_addr_q;
    assign bus.m68k_ack   = m68k_ack_q;
    assign bus.z80_ack    = z80_ack_q;
    assign bus.gfx_ack    = gfx_ack_q;
    assign bus.m68k_dout  = m68k_dout_q;
    assign bus.z80_dout   = z80_dout_q;
    assign bus.gfx_dout   = gfx_dout_q;
endmodule
